// File: rtl/sram_rw_ctrl.sv
// Valid/ready command front-end for a single-port 1024x8 SRAM macro with a credit-protected read-response FIFO.
// Optional power-on clear walk of the whole array is enabled by defining SRAM_CTRL_INIT_EN.
module sram_rw_ctrl #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned RSP_DEPTH  = 4
) (
  input  logic                  clk0,
  input  logic                  rstb0,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_we,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  init_done,
  output logic                  csb0,
  output logic                  web0,
  output logic [ADDR_WIDTH-1:0] addr0,
  output logic [DATA_WIDTH-1:0] din0,
  input  logic [DATA_WIDTH-1:0] dout0
);

  localparam int unsigned CW = $clog2(RSP_DEPTH + 1);
  localparam int unsigned PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;

  typedef enum logic {S_INIT = 1'b0, S_RUN = 1'b1} state_t;

`ifdef SRAM_CTRL_INIT_EN
  localparam state_t RESET_STATE = S_INIT;
`else
  localparam state_t RESET_STATE = S_RUN;
`endif

  state_t state_q, state_d;

  logic                  csb_d, web_d;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [DATA_WIDTH-1:0] din_d;
  logic                  cmd_ready_d, init_done_d;
  logic [CW-1:0]         outstanding_q, outstanding_d;
  logic                  rd_p1_q, rd_p2_q;
  logic                  cmd_fire, rd_fire, pop, push;

  logic [DATA_WIDTH-1:0] fifo_mem [RSP_DEPTH];
  logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]         fifo_cnt_q;

`ifdef SRAM_CTRL_INIT_EN
  logic [ADDR_WIDTH-1:0] init_addr_q;
`endif

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign cmd_fire = cmd_valid && cmd_ready;
  assign rd_fire  = cmd_fire && !cmd_we;
  assign pop      = rsp_valid && rsp_ready;
  assign push     = rd_p2_q;

  // State register
  always_ff @(posedge clk0 or negedge rstb0) begin
    if (!rstb0) state_q <= RESET_STATE;
    else        state_q <= state_d;
  end

  // Next-state logic: INIT leaves once the last clear write is issued
  always_comb begin
    state_d = state_q;
`ifdef SRAM_CTRL_INIT_EN
    if (state_q == S_INIT && (&init_addr_q)) state_d = S_RUN;
`endif
  end

  // Output logic: next values of the macro drive, credit and handshake registers
  always_comb begin
    csb_d  = 1'b1;
    web_d  = web0;
    addr_d = addr0;
    din_d  = din0;
`ifdef SRAM_CTRL_INIT_EN
    if (state_q == S_INIT) begin
      csb_d  = 1'b0;
      web_d  = 1'b0;
      addr_d = init_addr_q;
      din_d  = '0;
    end else
`endif
    if (cmd_fire) begin
      csb_d  = 1'b0;
      web_d  = !cmd_we;
      addr_d = cmd_addr;
      din_d  = cmd_wdata;
    end
    outstanding_d = outstanding_q + CW'(rd_fire) - CW'(pop);
    cmd_ready_d   = (state_d == S_RUN) && (outstanding_d < CW'(RSP_DEPTH));
    init_done_d   = (state_d == S_RUN);
  end

  always_ff @(posedge clk0 or negedge rstb0) begin
    if (!rstb0) begin
      csb0          <= 1'b1;
      web0          <= 1'b1;
      addr0         <= '0;
      din0          <= '0;
      cmd_ready     <= 1'b0;
      init_done     <= 1'b0;
      outstanding_q <= '0;
      rd_p1_q       <= 1'b0;
      rd_p2_q       <= 1'b0;
    end else begin
      csb0          <= csb_d;
      web0          <= web_d;
      addr0         <= addr_d;
      din0          <= din_d;
      cmd_ready     <= cmd_ready_d;
      init_done     <= init_done_d;
      outstanding_q <= outstanding_d;
      rd_p1_q       <= rd_fire;
      rd_p2_q       <= rd_p1_q;
    end
  end

`ifdef SRAM_CTRL_INIT_EN
  always_ff @(posedge clk0 or negedge rstb0) begin
    if (!rstb0)                 init_addr_q <= '0;
    else if (state_q == S_INIT) init_addr_q <= init_addr_q + ADDR_WIDTH'(1);
  end
`endif

  // Response FIFO; credits guarantee a push never lands on a full FIFO
  always_ff @(posedge clk0 or negedge rstb0) begin
    if (!rstb0) begin
      fifo_mem   <= '{default: '0};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr_q] <= dout0;
        wr_ptr_q           <= ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      fifo_cnt_q <= fifo_cnt_q + CW'(push) - CW'(pop);
    end
  end

  assign rsp_valid = (fifo_cnt_q != '0);
  assign rsp_rdata = fifo_mem[rd_ptr_q];

endmodule

// File: tb/tb_sram_rw_ctrl.sv
// Directed bench for sram_rw_ctrl with a behavioural 1024x8 macro model (inputs registered on posedge,
// array access on the following negedge).
module tb_sram_rw_ctrl;

  logic       clk0;
  logic       rstb0 = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_we = 1'b0;
  logic [9:0] cmd_addr = '0;
  logic [7:0] cmd_wdata = '0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [7:0] rsp_rdata;
  logic       init_done;
  logic       csb0, web0;
  logic [9:0] addr0;
  logic [7:0] din0;
  logic [7:0] dout0;

  int passed = 0;
  int total  = 0;

  sram_rw_ctrl dut (
    .clk0(clk0), .rstb0(rstb0),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .init_done(init_done),
    .csb0(csb0), .web0(web0), .addr0(addr0), .din0(din0), .dout0(dout0)
  );

  initial clk0 = 1'b0;
  always #5 clk0 = ~clk0;

  // Macro model
  logic [7:0] mem [1024];
  logic       m_csb, m_web;
  logic [9:0] m_addr;
  logic [7:0] m_din;
  always @(posedge clk0) begin
    m_csb  <= csb0;
    m_web  <= web0;
    m_addr <= addr0;
    m_din  <= din0;
  end
  always @(negedge clk0) begin
    if (m_csb === 1'b0 && m_web === 1'b0) mem[m_addr] <= m_din;
    if (m_csb === 1'b0 && m_web === 1'b1) dout0 <= mem[m_addr];
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk0);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Write then immediately read the same address, checking drive and exact read latency
  task automatic wr_rd(input string tag, input logic [9:0] a, input logic [7:0] d);
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = a; cmd_wdata = d;
    chk({tag, ".wr_ready"}, 32'(cmd_ready), 32'h1);
    tick();
    chk({tag, ".wr_csb0"}, 32'(csb0), 32'h0);
    chk({tag, ".wr_web0"}, 32'(web0), 32'h0);
    chk({tag, ".wr_addr0"}, 32'(addr0), 32'(a));
    chk({tag, ".wr_din0"}, 32'(din0), 32'(d));
    cmd_we = 1'b0;
    chk({tag, ".rd_ready"}, 32'(cmd_ready), 32'h1);
    tick();
    cmd_valid = 1'b0;
    chk({tag, ".rd_web0"}, 32'(web0), 32'h1);
    chk({tag, ".lat0"}, 32'(rsp_valid), 32'h0);
    tick();
    chk({tag, ".lat1"}, 32'(rsp_valid), 32'h0);
    tick();
    chk({tag, ".lat2"}, 32'(rsp_valid), 32'h1);
    chk({tag, ".rdata"}, 32'(rsp_rdata), 32'(d));
    tick();
    chk({tag, ".popped"}, 32'(rsp_valid), 32'h0);
  endtask

  initial begin
    int n;
    int acc;
    int seen;

    // Reset values
    #2 rstb0 = 1'b0;
    tick(); tick();
    chk("rst.cmd_ready", 32'(cmd_ready), 32'h0);
    chk("rst.rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst.rsp_rdata", 32'(rsp_rdata), 32'h0);
    chk("rst.init_done", 32'(init_done), 32'h0);
    chk("rst.csb0", 32'(csb0), 32'h1);
    chk("rst.web0", 32'(web0), 32'h1);
    chk("rst.addr0", 32'(addr0), 32'h0);
    chk("rst.din0", 32'(din0), 32'h0);
    rstb0 = 1'b1;
    rsp_ready = 1'b1;

`ifdef SRAM_CTRL_INIT_EN
    // Clear walk: init_done after 1024 cycles, cleared locations read back zero
    n = 0;
    tick(); n++;
    chk("init.cmd_ready_low", 32'(cmd_ready), 32'h0);
    while (init_done !== 1'b1 && n < 3000) begin
      tick(); n++;
    end
    chk("init.cycles", 32'(n), 32'd1024);
    tick();
    chk("init.cmd_ready", 32'(cmd_ready), 32'h1);
    cmd_valid = 1'b1; cmd_we = 1'b0;
    cmd_addr = 10'h000; tick();
    cmd_addr = 10'h155; tick();
    cmd_addr = 10'h3FF; tick();
    cmd_valid = 1'b0;
    chk("init.rsp0_valid", 32'(rsp_valid), 32'h1);
    chk("init.rsp0", 32'(rsp_rdata), 32'h0);
    tick();
    chk("init.rsp1_valid", 32'(rsp_valid), 32'h1);
    chk("init.rsp1", 32'(rsp_rdata), 32'h0);
    tick();
    chk("init.rsp2_valid", 32'(rsp_valid), 32'h1);
    chk("init.rsp2", 32'(rsp_rdata), 32'h0);
    tick();
    chk("init.drained", 32'(rsp_valid), 32'h0);
`else
    tick();
    chk("run.init_done", 32'(init_done), 32'h1);
    chk("run.cmd_ready", 32'(cmd_ready), 32'h1);
`endif

    // Top-address write/read latency, then write followed by same-address read
    wr_rd("t1", 10'h3FF, 8'hA5);
    wr_rd("t4", 10'h005, 8'h3C);

    // 16 back-to-back writes, then 16 back-to-back reads
    cmd_valid = 1'b1; cmd_we = 1'b1;
    for (int i = 0; i < 16; i++) begin
      cmd_addr = 10'(i); cmd_wdata = 8'(i);
      tick();
    end
    cmd_we = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (k < 16) begin
        cmd_valid = 1'b1; cmd_addr = 10'(k);
        chk("burst.cmd_ready", 32'(cmd_ready), 32'h1);
      end else begin
        cmd_valid = 1'b0;
      end
      tick();
      chk("burst.rsp_valid", 32'(rsp_valid), 32'((k >= 2) && (k <= 17)));
      if (k >= 2 && k <= 17) chk("burst.rdata", 32'(rsp_rdata), 32'(k - 2));
    end

    // Backpressure: only RSP_DEPTH reads accepted, drained in order
    rsp_ready = 1'b0;
    acc = 0;
    cmd_valid = 1'b1; cmd_we = 1'b0;
    for (int k = 0; k < 8; k++) begin
      cmd_addr = 10'(10 + acc);
      n = int'(cmd_ready);
      tick();
      acc += n;
    end
    cmd_valid = 1'b0;
    chk("bp.accepted", 32'(acc), 32'd4);
    chk("bp.cmd_ready_low", 32'(cmd_ready), 32'h0);
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("bp.rsp_valid", 32'(rsp_valid), 32'h1);
      chk("bp.rdata", 32'(rsp_rdata), 32'(8'h0A + i));
      tick();
      if (i == 0) chk("bp.cmd_ready_back", 32'(cmd_ready), 32'h1);
    end
    chk("bp.drained", 32'(rsp_valid), 32'h0);

    // Asynchronous reset with two reads in flight
    cmd_valid = 1'b1; cmd_we = 1'b0;
    cmd_addr = 10'd1; tick();
    cmd_addr = 10'd2; tick();
    cmd_valid = 1'b0;
    #2 rstb0 = 1'b0;
    #1;
    chk("arst.rsp_valid", 32'(rsp_valid), 32'h0);
    chk("arst.csb0", 32'(csb0), 32'h1);
    chk("arst.cmd_ready", 32'(cmd_ready), 32'h0);
    chk("arst.addr0", 32'(addr0), 32'h0);
    tick(); tick();
    rstb0 = 1'b1;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (rsp_valid !== 1'b0) seen++;
    end
    chk("arst.no_rsp", 32'(seen), 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
